// File: rtl/bram_port_master.sv
// bram_port_master: valid/ready initiator for one byte-masked BRAM port with an in-order read response FIFO
//   clk_i, rstn_i                 clock, async active-low reset
//   req_valid_i/req_ready_o       request handshake; req_wr_i selects write, req_addr_i/req_data_i/req_mask_i fields
//   rsp_valid_o/rsp_ready_i       read response handshake; rsp_data_o is read data in request order
//   bram_cmd_en_o..bram_mask_o    combinational command drive to the BRAM port
//   bram_data_i                   BRAM registered read data, valid one cycle after a read command
//   busy_o                        read in flight or responses pending
module bram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 128,
  parameter int RSP_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [MASK_WIDTH-1:0] req_mask_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  bram_cmd_en_o,
  output logic                  bram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_data_o,
  output logic [MASK_WIDTH-1:0] bram_mask_o,
  input  logic [DATA_WIDTH-1:0] bram_data_i,
  output logic                  busy_o
);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW:0] CREDITS = (CW+1)'(RSP_DEPTH);
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic                  fire, push, pop;
  // A read in flight already owns a FIFO slot, so the FIFO can never overflow.
  assign req_ready_o = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < CREDITS;
  assign fire = req_valid_i & req_ready_o;
  assign push = inflight_q;
  assign pop = rsp_valid_o & rsp_ready_i;
  assign rsp_valid_o = count_q != '0;
  assign rsp_data_o = mem_q[rd_ptr_q];
  assign busy_o = inflight_q | rsp_valid_o;
  assign bram_cmd_en_o = fire;
  assign bram_wr_en_o = fire & req_wr_i;
  assign bram_addr_o = req_addr_i;
  assign bram_data_o = req_data_i;
  assign bram_mask_o = fire ? req_mask_i : '0;
  always_comb begin
    inflight_d = fire & ~req_wr_i;
    wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_q <= 1'b0;
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bram_data_i;
  end
endmodule

// File: tb/tb_bram_port_master.sv
// tb_bram_port_master: directed and random checks of bram_port_master against a transaction-level model
module tb_bram_port_master;
  localparam int DW = 32, AW = 7, MW = 4, D = 4, NW = 128;
  logic clk_i = 1'b0, rstn_i = 1'b0;
  logic req_valid_i = 1'b0, req_wr_i = 1'b0, rsp_ready_i = 1'b1;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic [MW-1:0] req_mask_i = '0;
  logic req_ready_o, rsp_valid_o, bram_cmd_en_o, bram_wr_en_o, busy_o;
  logic [DW-1:0] rsp_data_o, bram_data_o, bram_data_i;
  logic [AW-1:0] bram_addr_o;
  logic [MW-1:0] bram_mask_o;
  always #5 clk_i = ~clk_i;
  bram_port_master #(.DATA_WIDTH(DW), .BRAM_DEPTH(NW), .RSP_DEPTH(D)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .bram_cmd_en_o(bram_cmd_en_o), .bram_wr_en_o(bram_wr_en_o), .bram_addr_o(bram_addr_o),
    .bram_data_o(bram_data_o), .bram_mask_o(bram_mask_o), .bram_data_i(bram_data_i),
    .busy_o(busy_o)
  );
  // Byte-masked BRAM port with a registered read output (not reset).
  logic [DW-1:0] bram_mem [NW];
  logic [DW-1:0] bram_q = '0;
  assign bram_data_i = bram_q;
  always @(posedge clk_i) begin
    if (bram_cmd_en_o) begin
      if (bram_wr_en_o) begin
        for (int b = 0; b < MW; b++)
          if (bram_mask_o[b]) bram_mem[bram_addr_o][8*b +: 8] = bram_data_o[8*b +: 8];
      end else bram_q <= bram_mem[bram_addr_o];
    end
  end
  // Reference: every accepted read owes one response, oldest first, no earlier than two cycles after acceptance.
  typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] ref_mem [NW];
  int n_cmp = 0, n_err = 0, cyc = 0, pops = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      exp_q.delete();
      check("rst_ready", req_ready_o, 1);
      check("rst_valid", rsp_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_cmd_en", bram_cmd_en_o, 0);
    end else begin
      logic er, ev, ef;
      exp_t e;
      er = exp_q.size() < D;
      ev = exp_q.size() != 0 && cyc >= exp_q[0].cyc + 2;
      ef = req_valid_i & er;
      check("req_ready", req_ready_o, er);
      check("rsp_valid", rsp_valid_o, ev);
      check("busy", busy_o, exp_q.size() != 0);
      check("cmd_en", bram_cmd_en_o, ef);
      check("wr_en", bram_wr_en_o, ef & req_wr_i);
      check("mask", bram_mask_o, ef ? req_mask_i : '0);
      if (ef) begin
        check("addr", bram_addr_o, req_addr_i);
        check("wdata", bram_data_o, req_data_i);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) check("pop_empty", rsp_valid_o, 0);
        else begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data_o, e.data);
          pops++;
        end
      end
      if (ef) begin
        if (req_wr_i) begin
          for (int b = 0; b < MW; b++)
            if (req_mask_i[b]) ref_mem[req_addr_i][8*b +: 8] = req_data_i[8*b +: 8];
        end else exp_q.push_back('{data: ref_mem[req_addr_i], cyc: cyc});
      end
    end
  end
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n = 0;
    req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = a; req_data_i = d; req_mask_i = m;
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin n++; @(negedge clk_i); end
    if (n == 50) check("issue_timeout", req_ready_o, 1);
    step();
    req_valid_i = 1'b0; req_wr_i = 1'b0;
  endtask
  task automatic await_rsp(input string tag, input logic [DW-1:0] exp);
    @(negedge clk_i);
    check({tag, "_early"}, rsp_valid_o, 0);
    step();
    @(negedge clk_i);
    check({tag, "_valid"}, rsp_valid_o, 1);
    check({tag, "_data"}, rsp_data_o, exp);
    step();
  endtask
  task automatic drain();
    int n = 0;
    rsp_ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin n++; step(); end
    check("drain_done", exp_q.size(), 0);
  endtask
  initial begin
    int fired, p0;
    logic [DW-1:0] old_v;
    for (int i = 0; i < NW; i++) begin
      bram_mem[i] = $urandom;
      ref_mem[i] = bram_mem[i];
    end
    repeat (3) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    step();
    issue(1'b1, 7'd5, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 7'd5, '0, '0);
    await_rsp("t1", 32'hDEADBEEF);
    drain();
    issue(1'b1, 7'd7, 32'h11223344, 4'hF);
    issue(1'b1, 7'd7, 32'hAABBCCDD, 4'h5);
    issue(1'b0, 7'd7, '0, '0);
    await_rsp("t2", 32'h11BB33DD);
    drain();
    rsp_ready_i = 1'b0; fired = 0; p0 = pops;
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = '0;
    for (int c = 0; c < 40 && fired < 6; c++) begin
      @(negedge clk_i);
      if (req_ready_o) fired++;
      if (c == 9) begin
        check("bp_accepted", fired, 4);
        check("bp_ready_low", req_ready_o, 0);
      end
      step();
      req_addr_i = AW'(fired);
      req_valid_i = fired < 6;
      if (c == 9) rsp_ready_i = 1'b1;
    end
    req_valid_i = 1'b0;
    check("bp_all_fired", fired, 6);
    drain();
    check("bp_pops", pops - p0, 6);
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_addr_i = 7'd20;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      if (i < 8) check("b2b_ready", req_ready_o, 1);
      check("b2b_valid", rsp_valid_o, i >= 2 && i <= 9);
      step();
      req_addr_i = AW'(21 + i);
      if (i == 7) req_valid_i = 1'b0;
    end
    drain();
    old_v = ref_mem[3];
    issue(1'b0, 7'd3, '0, '0);
    issue(1'b1, 7'd3, ~old_v, 4'hF);
    @(negedge clk_i);
    check("rw_old_valid", rsp_valid_o, 1);
    check("rw_old_data", rsp_data_o, old_v);
    step();
    issue(1'b0, 7'd3, '0, '0);
    await_rsp("rw_new", ~old_v);
    drain();
    rsp_ready_i = 1'b0;
    issue(1'b0, 7'd10, '0, '0);
    issue(1'b0, 7'd11, '0, '0);
    issue(1'b0, 7'd12, '0, '0);
    rstn_i = 1'b0;
    #1;
    check("arst_ready", req_ready_o, 1);
    check("arst_valid", rsp_valid_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_cmd_en", bram_cmd_en_o, 0);
    step();
    step();
    rstn_i = 1'b1;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("post_rst_valid", rsp_valid_o, 0);
      step();
    end
    issue(1'b0, 7'd10, '0, '0);
    await_rsp("post_rst_rd", ref_mem[10]);
    drain();
    for (int i = 0; i < 600; i++) begin
      req_valid_i = ($urandom % 4) != 0;
      req_wr_i = ($urandom % 3) == 0;
      req_addr_i = AW'($urandom_range(0, 15));
      req_data_i = $urandom;
      req_mask_i = MW'($urandom);
      rsp_ready_i = (i < 300) ? ($urandom % 3) == 0 : ($urandom % 4) != 0;
      step();
    end
    req_valid_i = 1'b0;
    drain();
    step();
    @(negedge clk_i);
    check("final_busy", busy_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
